corevx_alu_wb: RTL

// - Writeback stage directly downstream of the ALU.
// - Captures ALU result, destination register, PC and unknown_operation into a 2-entry skid buffer.
// - Drives the register-file write port; turns unknown_operation into an illegal-instruction trap.
// - Counts retired instructions.

---
 rtl/corevx_alu_wb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/corevx_alu_wb.sv
// corevx_alu_wb: ALU writeback stage with a 2-entry skid buffer, register-file write port,
// illegal-instruction trap and wrapping retire counter. Define COREVX_WB_BYPASS_EN for forwarding.
module corevx_alu_wb #(
   parameter int unsigned COUNT_W    = 32,
   parameter logic [31:0] TRAP_CAUSE = 32'd2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_result,
   input  logic               in_unknown_op,
   input  logic [4:0]         in_rd,
   input  logic [31:0]        in_pc,
   output logic               rf_write,
   output logic [4:0]         rf_waddr,
   output logic [31:0]        rf_wdata,
   input  logic               rf_ready,
   output logic               trap_valid,
   output logic [31:0]        trap_pc,
   output logic [31:0]        trap_cause,
   input  logic               trap_ack,
   output logic [COUNT_W-1:0] retire_count,
   output logic [1:0]         byp_valid,
   output logic [9:0]         byp_rd,
   output logic [63:0]        byp_data
);

   typedef struct packed {
      logic [31:0] result;
      logic        unknown_op;
      logic [4:0]  rd;
      logic [31:0] pc;
   } entry_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

   occ_t               state_q;
   entry_t             head_q;
   entry_t             skid_q;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;

   entry_t in_entry;
   logic   head_valid;
   logic   head_trap;
   logic   pop;
   logic   push;

   assign in_entry   = {in_result, in_unknown_op, in_rd, in_pc};
   assign head_valid = (state_q != EMPTY);
   assign head_trap  = head_valid && head_q.unknown_op;
   // x0 destinations retire without waiting for the register file.
   assign pop        = head_valid && !head_q.unknown_op && ((head_q.rd == 5'd0) || rf_ready);
   assign in_ready   = (state_q != TWO) && !head_trap;
   assign push       = in_valid && in_ready;
   assign count_d    = count_q + COUNT_W'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         count_q <= '0;
      end else begin
         // A write completing in a flush cycle still retires.
         count_q <= count_d;
         if (flush || (trap_ack && head_trap)) begin
            state_q <= EMPTY;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (push) begin
                     head_q  <= in_entry;
                     state_q <= ONE;
                  end
               end
               ONE: begin
                  if (push && pop) begin
                     head_q <= in_entry;
                  end else if (pop) begin
                     state_q <= EMPTY;
                  end else if (push) begin
                     skid_q  <= in_entry;
                     state_q <= TWO;
                  end
               end
               TWO: begin
                  if (pop) begin
                     head_q  <= skid_q;
                     state_q <= ONE;
                  end
               end
               default: state_q <= EMPTY;
            endcase
         end
      end
   end

   assign rf_write     = head_valid && !head_q.unknown_op && (head_q.rd != 5'd0);
   assign rf_waddr     = rf_write ? head_q.rd : 5'd0;
   assign rf_wdata     = rf_write ? head_q.result : 32'd0;
   assign trap_valid   = head_trap;
   assign trap_pc      = head_trap ? head_q.pc : 32'd0;
   assign trap_cause   = head_trap ? TRAP_CAUSE : 32'd0;
   assign retire_count = count_q;

`ifdef COREVX_WB_BYPASS_EN
   entry_t [1:0] ent;
   logic   [1:0] ent_valid;

   assign ent[0]       = head_q;
   assign ent[1]       = skid_q;
   assign ent_valid[0] = head_valid;
   assign ent_valid[1] = (state_q == TWO);

   // Slot 1 (skid) is younger: consumers must prefer it when both rd fields match.
   for (genvar gi = 0; gi < 2; gi++) begin : g_byp
      logic fwd;
      assign fwd                     = ent_valid[gi] && !ent[gi].unknown_op && (ent[gi].rd != 5'd0);
      assign byp_valid[gi]           = fwd;
      assign byp_rd[gi*5 +: 5]       = fwd ? ent[gi].rd : 5'd0;
      assign byp_data[gi*32 +: 32]   = fwd ? ent[gi].result : 32'd0;
   end
`else
   assign byp_valid = 2'b00;
   assign byp_rd    = 10'd0;
   assign byp_data  = 64'd0;
`endif

endmodule
